// File: rtl/div_pkg.sv
// Shared types and helpers for the run-time clock divider controller.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} div_state_t;

    localparam int unsigned DIV_MIN_LIMIT = 2;
    localparam int unsigned DIV_ARG_W     = 64;

    // Callers zero-extend their fields, so all compares stay unsigned.
    function automatic logic div_cfg_ok(input logic [DIV_ARG_W-1:0] limit,
                                        input logic [DIV_ARG_W-1:0] high);
        return (limit >= DIV_ARG_W'(DIV_MIN_LIMIT)) && (high != '0) && (high < limit);
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Config handshake between register logic (master) and the divider controller (slave).
interface div_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CNT_WIDTH-1:0] cfg_limit;
    logic [CNT_WIDTH-1:0] cfg_high;
    logic                 cfg_err;

    modport master (
        output cfg_valid, cfg_limit, cfg_high,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_limit, cfg_high,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/div_cfg_slot.sv
// Config intake: handshake, validation, one-deep shadow set and the load request
// that updates the controller's active period/high-time.
module div_cfg_slot
    import div_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 idle,
    input  logic                 apply,
    div_ctrl_if.slave            cfg,
    output logic                 load,
    output logic [CNT_WIDTH-1:0] load_limit,
    output logic [CNT_WIDTH-1:0] load_high
);

    logic [CNT_WIDTH-1:0] limit_n;
    logic [CNT_WIDTH-1:0] high_n;
    logic                 pend;
    logic                 err_q;
    logic                 accept;
    logic                 cfg_ok;

    assign cfg.cfg_ready = !pend && !rst;
    assign cfg.cfg_err   = err_q;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_ok        = div_cfg_ok(DIV_ARG_W'(cfg.cfg_limit), DIV_ARG_W'(cfg.cfg_high));

    // A pending set and a direct idle write never coincide: accept requires !pend.
    always_comb begin
        load       = 1'b0;
        load_limit = limit_n;
        load_high  = high_n;
        if (apply && pend) begin
            load = 1'b1;
        end else if (accept && cfg_ok && idle) begin
            load       = 1'b1;
            load_limit = cfg.cfg_limit;
            load_high  = cfg.cfg_high;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            pend    <= 1'b0;
            err_q   <= 1'b0;
            limit_n <= '0;
            high_n  <= '0;
        end else begin
            err_q <= accept && !cfg_ok;
            if (accept && cfg_ok && !idle) begin
                pend    <= 1'b1;
                limit_n <= cfg.cfg_limit;
                high_n  <= cfg.cfg_high;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Glitch-free run-time clock divider controller: start/stop sequencing, period counter,
// registered div_clk/tick outputs, and period-boundary config reload.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned DEF_LIMIT = 125000000,
    parameter int unsigned DEF_HIGH  = DEF_LIMIT / 2
) (
    input  logic      sclk,
    input  logic      rst,
    input  logic      run,
    div_ctrl_if.slave cfg,
    output logic      div_clk,
    output logic      tick,
    output logic      busy
);

    div_state_t           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] limit_r, high_r;
    logic [CNT_WIDTH-1:0] load_limit, load_high;
    logic                 load;
    logic                 wrap;
    logic                 idle;
    logic                 div_clk_q, tick_q;

    assign idle    = (state_q == IDLE);
    assign wrap    = !idle && (cnt_q == limit_r - CNT_WIDTH'(1));
    assign busy    = !idle;
    assign div_clk = div_clk_q;
    assign tick    = tick_q;

    // Idle also applies a set left pending by a config taken on the final stop wrap.
    div_cfg_slot #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cfg_slot (
        .sclk       (sclk),
        .rst        (rst),
        .idle       (idle),
        .apply      (wrap || idle),
        .cfg        (cfg),
        .load       (load),
        .load_limit (load_limit),
        .load_high  (load_high)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run) state_d = RUN;
            end
            RUN: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
                if (!run) state_d = STOP;
            end
            STOP: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_WIDTH'(1);
                if (run) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            limit_r   <= CNT_WIDTH'(DEF_LIMIT);
            high_r    <= CNT_WIDTH'(DEF_HIGH);
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_clk_q <= !idle && (cnt_q < high_r);
            tick_q    <= wrap;
            if (load) begin
                limit_r <= load_limit;
                high_r  <= load_high;
            end
        end
    end

endmodule
